updown_counter_bcd: RTL and testbench

Parametrised N-digit BCD up/down counter with a built-in tick prescaler, a programmable terminal value and a wrap strobe. It is the next-generation counting core for the FND display path: its BCD output feeds the digit multiplexer directly, with no binary-to-BCD split. It also serves as a reusable timebase for later stopwatch and clock blocks.

---
 rtl/udc_pkg.sv | 35 +++
 rtl/bcd_digit_cell.sv | 35 +++
 rtl/updown_counter_bcd.sv | 151 +++++++++++++++
 tb/tb_updown_counter_bcd.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared constants and BCD helpers for the up/down BCD counter.
// The helpers work on a fixed 8-digit (32-bit) vector; callers slice to their width.
package udc_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;
    localparam int BCD_FULL_W = BCD_W * MAX_DIGITS;

    // Decimal integer to packed BCD, digit 0 in bits [3:0].
    function automatic logic [BCD_FULL_W-1:0] dec_to_bcd(input int unsigned value);
        logic [BCD_FULL_W-1:0] result;
        int unsigned           rest;
        result = '0;
        rest   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            result[i*BCD_W +: BCD_W] = BCD_W'(rest % 10);
            rest = rest / 10;
        end
        return result;
    endfunction

    // True when every one of the low 'digits' nibbles is in 0..9.
    function automatic logic bcd_is_valid(input logic [BCD_FULL_W-1:0] value,
                                          input int                    digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && value[i*BCD_W +: BCD_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the increment/decrement chain.
// Passes the digit through unchanged when not enabled; carry means "enable the next digit".
module bcd_digit_cell
    import udc_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             en,
    input  logic             down,
    output logic [BCD_W-1:0] next_digit,
    output logic             carry
);

    always_comb begin
        next_digit = digit;
        carry      = 1'b0;
        if (en) begin
            if (down) begin
                if (digit == 4'd0) begin
                    next_digit = 4'd9;
                    carry      = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end else begin
                if (digit >= 4'd9) begin
                    next_digit = 4'd0;
                    carry      = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_bcd.sv
// N-digit BCD up/down counter with tick prescaler, terminal value and wrap strobe.
// Define UDC_LOAD_EN to build the parallel-load path and the load-error strobe.
module updown_counter_bcd
    import udc_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 100_000,
    parameter int MAX_VALUE = 9999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mode,
    input  logic                  i_run_stop,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [BCD_W*DIGITS-1:0] i_load_data,
    output logic [BCD_W*DIGITS-1:0] o_bcd,
    output logic                  o_tick,
    output logic                  o_wrap,
    output logic                  o_load_err
);

    localparam int W  = BCD_W * DIGITS;
    localparam int PW = $clog2(CLK_DIV);

    localparam logic [BCD_FULL_W-1:0] MAX_BCD_FULL = dec_to_bcd(MAX_VALUE);
    localparam logic [W-1:0]          MAX_BCD      = MAX_BCD_FULL[W-1:0];
    localparam logic [PW-1:0]         PRESC_LAST   = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic [W-1:0]  bcd_reg, bcd_next;
    logic          tick_reg, tick_next;
    logic          wrap_reg, wrap_next;
    logic          tick_int;
    logic          at_max;
    logic          at_zero;

    // Ripple chain: digit 0 is always enabled, each carry/borrow enables the next digit.
    logic [DIGITS:0] chain_en;
    logic [W-1:0]    step_val;
    logic            unused_top_carry;

    assign chain_en[0]      = 1'b1;
    assign unused_top_carry = chain_en[DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_cell u_cell (
                .digit      (bcd_reg[gi*BCD_W +: BCD_W]),
                .en         (chain_en[gi]),
                .down       (i_mode),
                .next_digit (step_val[gi*BCD_W +: BCD_W]),
                .carry      (chain_en[gi+1])
            );
        end
    endgenerate

    assign tick_int = i_run_stop && (presc_reg == PRESC_LAST);
    assign at_max   = (bcd_reg == MAX_BCD);
    assign at_zero  = (bcd_reg == '0);

`ifdef UDC_LOAD_EN
    logic load_err_reg, load_err_next;
    logic load_ok;

    // Valid BCD compares in the same order as its decimal value.
    assign load_ok = bcd_is_valid(BCD_FULL_W'(i_load_data), DIGITS) && (i_load_data <= MAX_BCD);
`else
    logic unused_load;
    assign unused_load = ^{i_load, i_load_data};
`endif

    always_comb begin
        presc_next = presc_reg;
        bcd_next   = bcd_reg;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
`ifdef UDC_LOAD_EN
        load_err_next = 1'b0;
`endif
        if (i_run_stop) begin
            presc_next = tick_int ? '0 : presc_reg + PW'(1);
        end

        if (i_clear) begin
            bcd_next   = '0;
            presc_next = '0;
        end
`ifdef UDC_LOAD_EN
        else if (i_load) begin
            tick_next = tick_int;
            if (load_ok) begin
                bcd_next = i_load_data;
            end else begin
                load_err_next = 1'b1;
            end
        end
`endif
        else if (tick_int) begin
            tick_next = 1'b1;
            if (i_mode) begin
                if (at_zero) begin
                    bcd_next  = MAX_BCD;
                    wrap_next = 1'b1;
                end else begin
                    bcd_next = step_val;
                end
            end else begin
                if (at_max) begin
                    bcd_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    bcd_next = step_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
            bcd_reg   <= '0;
            tick_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            bcd_reg   <= bcd_next;
            tick_reg  <= tick_next;
            wrap_reg  <= wrap_next;
        end
    end

`ifdef UDC_LOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_err_reg <= 1'b0;
        end else begin
            load_err_reg <= load_err_next;
        end
    end

    assign o_load_err = load_err_reg;
`else
    assign o_load_err = 1'b0;
`endif

    assign o_bcd  = bcd_reg;
    assign o_tick = tick_reg;
    assign o_wrap = wrap_reg;

endmodule

// File: tb/tb_updown_counter_bcd.sv
// Directed bench for updown_counter_bcd: a 4-digit/9999 instance and a 2-digit/59 instance.
// Load scenarios follow UDC_LOAD_EN so the bench matches either build.
module tb_updown_counter_bcd;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        a_mode, a_run, a_clear, a_load;
    logic [15:0] a_load_data, a_bcd;
    logic        a_tick, a_wrap, a_err;

    logic        b_mode, b_run, b_clear, b_load;
    logic [7:0]  b_load_data, b_bcd;
    logic        b_tick, b_wrap, b_err;

    updown_counter_bcd #(.DIGITS(4), .CLK_DIV(4), .MAX_VALUE(9999)) dut_a (
        .clk(clk), .reset(reset), .i_mode(a_mode), .i_run_stop(a_run),
        .i_clear(a_clear), .i_load(a_load), .i_load_data(a_load_data),
        .o_bcd(a_bcd), .o_tick(a_tick), .o_wrap(a_wrap), .o_load_err(a_err)
    );

    updown_counter_bcd #(.DIGITS(2), .CLK_DIV(4), .MAX_VALUE(59)) dut_b (
        .clk(clk), .reset(reset), .i_mode(b_mode), .i_run_stop(b_run),
        .i_clear(b_clear), .i_load(b_load), .i_load_data(b_load_data),
        .o_bcd(b_bcd), .o_tick(b_tick), .o_wrap(b_wrap), .o_load_err(b_err)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_clear = 1'b1;
        step(1);
        a_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++; if (a_bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h expected %h", a_bcd, 16'h0000); end
        checks++; if ({a_tick, a_wrap, a_err} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected %b", {a_tick, a_wrap, a_err}, 3'b000); end
        checks++; if (b_bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd_b: got %h expected %h", b_bcd, 8'h00); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_count_up();
        clear_a();
        a_mode = 1'b0;
        a_run  = 1'b1;
        step(3);
        checks++; if (a_bcd !== 16'h0000) begin errors++; $display("FAIL up_latency: got %h expected %h", a_bcd, 16'h0000); end
        step(1);
        checks++; if (a_bcd !== 16'h0001) begin errors++; $display("FAIL up_first: got %h expected %h", a_bcd, 16'h0001); end
        checks++; if ({a_tick, a_wrap} !== 2'b10) begin errors++; $display("FAIL up_first_strobes: got %b expected %b", {a_tick, a_wrap}, 2'b10); end
        step(1);
        checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle: got %b expected %b", a_tick, 1'b0); end
        step(3 + 4 * 7);
        checks++; if (a_bcd !== 16'h0009) begin errors++; $display("FAIL up_to_9: got %h expected %h", a_bcd, 16'h0009); end
        step(4);
        checks++; if (a_bcd !== 16'h0010) begin errors++; $display("FAIL carry_9_to_10: got %h expected %h", a_bcd, 16'h0010); end
        checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL carry_no_wrap: got %b expected %b", a_wrap, 1'b0); end
        step(4 * 90);
        checks++; if (a_bcd !== 16'h0100) begin errors++; $display("FAIL up_to_100: got %h expected %h", a_bcd, 16'h0100); end
        $display("test_count_up done");
    endtask

    task automatic test_count_down();
        a_mode = 1'b1;
        step(4);
        checks++; if (a_bcd !== 16'h0099) begin errors++; $display("FAIL borrow_100_to_99: got %h expected %h", a_bcd, 16'h0099); end
        clear_a();
        step(4);
        checks++; if (a_bcd !== 16'h9999) begin errors++; $display("FAIL down_wrap: got %h expected %h", a_bcd, 16'h9999); end
        checks++; if (a_wrap !== 1'b1) begin errors++; $display("FAIL down_wrap_strobe: got %b expected %b", a_wrap, 1'b1); end
        step(1);
        checks++; if ({a_wrap, a_bcd} !== {1'b0, 16'h9999}) begin errors++; $display("FAIL wrap_one_cycle: got %h expected %h", {a_wrap, a_bcd}, {1'b0, 16'h9999}); end
        a_mode = 1'b0;
        step(3);
        checks++; if ({a_wrap, a_bcd} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL up_wrap: got %h expected %h", {a_wrap, a_bcd}, {1'b1, 16'h0000}); end
        $display("test_count_down done");
    endtask

    task automatic test_pause();
        clear_a();
        step(2);
        a_run = 1'b0;
        step(10);
        checks++; if ({a_tick, a_bcd} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL pause_hold: got %h expected %h", {a_tick, a_bcd}, {1'b0, 16'h0000}); end
        a_run = 1'b1;
        step(1);
        checks++; if (a_bcd !== 16'h0000) begin errors++; $display("FAIL resume_early: got %h expected %h", a_bcd, 16'h0000); end
        step(1);
        checks++; if ({a_tick, a_bcd} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL resume_count: got %h expected %h", {a_tick, a_bcd}, {1'b1, 16'h0001}); end
        $display("test_pause done");
    endtask

    task automatic test_clear_priority();
        clear_a();
        a_mode = 1'b1;
        step(4);
        checks++; if (a_bcd !== 16'h9999) begin errors++; $display("FAIL prio_setup: got %h expected %h", a_bcd, 16'h9999); end
        step(3);
        a_clear = 1'b1; a_load = 1'b1; a_load_data = 16'h1234;
        step(1);
        a_clear = 1'b0; a_load = 1'b0; a_mode = 1'b0;
        checks++; if ({a_wrap, a_bcd} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL clear_over_load_tick: got %h expected %h", {a_wrap, a_bcd}, {1'b0, 16'h0000}); end
        $display("test_clear_priority done");
    endtask

    task automatic test_load_tick();
        clear_a();
        a_mode = 1'b0;
        step(3);
        a_load = 1'b1; a_load_data = 16'h1234;
        step(1);
        a_load = 1'b0;
`ifdef UDC_LOAD_EN
        checks++; if ({a_wrap, a_bcd} !== {1'b0, 16'h1234}) begin errors++; $display("FAIL load_with_tick: got %h expected %h", {a_wrap, a_bcd}, {1'b0, 16'h1234}); end
        step(4);
        checks++; if (a_bcd !== 16'h1235) begin errors++; $display("FAIL count_after_load: got %h expected %h", a_bcd, 16'h1235); end
        step(1);
        a_load = 1'b1; a_load_data = 16'h0500;
        step(1);
        a_load = 1'b0;
        checks++; if (a_bcd !== 16'h0500) begin errors++; $display("FAIL load_mid_presc: got %h expected %h", a_bcd, 16'h0500); end
        step(1);
        checks++; if (a_bcd !== 16'h0500) begin errors++; $display("FAIL load_keeps_presc_early: got %h expected %h", a_bcd, 16'h0500); end
        step(1);
        checks++; if (a_bcd !== 16'h0501) begin errors++; $display("FAIL load_keeps_presc: got %h expected %h", a_bcd, 16'h0501); end
`else
        checks++; if ({a_err, a_bcd} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL load_ignored: got %h expected %h", {a_err, a_bcd}, {1'b0, 16'h0001}); end
        step(4);
        checks++; if (a_bcd !== 16'h0002) begin errors++; $display("FAIL count_after_ignored_load: got %h expected %h", a_bcd, 16'h0002); end
`endif
        $display("test_load_tick done");
    endtask

    task automatic test_load_err();
        a_run = 1'b0;
        a_load = 1'b1; a_load_data = 16'h12A4;
        step(1);
        a_load = 1'b0;
`ifdef UDC_LOAD_EN
        checks++; if ({a_err, a_bcd} !== {1'b1, 16'h0501}) begin errors++; $display("FAIL bad_digit_reject: got %h expected %h", {a_err, a_bcd}, {1'b1, 16'h0501}); end
        step(1);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL load_err_one_cycle: got %b expected %b", a_err, 1'b0); end
`else
        checks++; if ({a_err, a_bcd} !== {1'b0, 16'h0002}) begin errors++; $display("FAIL load_err_tied: got %h expected %h", {a_err, a_bcd}, {1'b0, 16'h0002}); end
`endif
        $display("test_load_err done");
    endtask

    task automatic test_small_max();
        b_clear = 1'b1;
        step(1);
        b_clear = 1'b0;
        b_mode = 1'b1; b_run = 1'b1;
        step(4);
        checks++; if ({b_wrap, b_bcd} !== {1'b1, 8'h59}) begin errors++; $display("FAIL b_down_wrap: got %h expected %h", {b_wrap, b_bcd}, {1'b1, 8'h59}); end
        step(1);
        b_mode = 1'b0;
        step(3);
        checks++; if ({b_wrap, b_bcd} !== {1'b1, 8'h00}) begin errors++; $display("FAIL b_up_wrap: got %h expected %h", {b_wrap, b_bcd}, {1'b1, 8'h00}); end
        step(4 * 10);
        checks++; if (b_bcd !== 8'h10) begin errors++; $display("FAIL b_carry: got %h expected %h", b_bcd, 8'h10); end
        b_run = 1'b0;
        b_load = 1'b1; b_load_data = 8'h70;
        step(1);
        b_load = 1'b0;
`ifdef UDC_LOAD_EN
        checks++; if ({b_err, b_bcd} !== {1'b1, 8'h10}) begin errors++; $display("FAIL b_over_max_reject: got %h expected %h", {b_err, b_bcd}, {1'b1, 8'h10}); end
        b_load = 1'b1; b_load_data = 8'h59;
        step(1);
        b_load = 1'b0;
        checks++; if ({b_err, b_bcd} !== {1'b0, 8'h59}) begin errors++; $display("FAIL b_load_max: got %h expected %h", {b_err, b_bcd}, {1'b0, 8'h59}); end
`else
        checks++; if ({b_err, b_bcd} !== {1'b0, 8'h10}) begin errors++; $display("FAIL b_load_ignored: got %h expected %h", {b_err, b_bcd}, {1'b0, 8'h10}); end
`endif
        $display("test_small_max done");
    endtask

    task automatic test_reset_mid();
        a_run = 1'b1;
        clear_a();
        step(6);
        checks++; if (a_bcd !== 16'h0001) begin errors++; $display("FAIL mid_setup: got %h expected %h", a_bcd, 16'h0001); end
        #2 reset = 1'b1;
        #1;
        checks++; if (a_bcd !== 16'h0000) begin errors++; $display("FAIL async_reset: got %h expected %h", a_bcd, 16'h0000); end
        checks++; if (b_bcd !== 8'h00) begin errors++; $display("FAIL async_reset_b: got %h expected %h", b_bcd, 8'h00); end
        step(1);
        reset = 1'b0;
        step(3);
        checks++; if (a_bcd !== 16'h0000) begin errors++; $display("FAIL post_reset_early: got %h expected %h", a_bcd, 16'h0000); end
        step(1);
        checks++; if (a_bcd !== 16'h0001) begin errors++; $display("FAIL post_reset_count: got %h expected %h", a_bcd, 16'h0001); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1;
        a_mode = 1'b0; a_run = 1'b0; a_clear = 1'b0; a_load = 1'b0; a_load_data = '0;
        b_mode = 1'b0; b_run = 1'b0; b_clear = 1'b0; b_load = 1'b0; b_load_data = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_pause();
        test_clear_priority();
        test_load_tick();
        test_load_err();
        test_small_max();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
